// File: rtl/dmem_block_fetch_pkg.sv
// Shared crypto datapath package.
// Holds the fetch FSM states and the block width.
package dmem_block_fetch_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    ERR
  } fetch_state_t;

endpackage

// File: rtl/dmem_block_fetch.sv
// DMEM block fetch controller.
// Reads blocks on data_ready rising edges and hands them to the core.
module dmem_block_fetch
  import dmem_block_fetch_pkg::*;
#(
  parameter int DATA_W  = BLOCK_W,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_blocks,
  output logic              dmem_read_enable,
  input  logic [DATA_W-1:0] dmem_read_data,
  input  logic              dmem_data_ready,
  output logic [DATA_W-1:0] blk_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [CNT_W-1:0]  blk_count,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  fetch_state_t      state_q, state_d;
  logic              ready_q;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic              rd_en_q, rd_en_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  nblk_q, nblk_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rise;
  logic              last_blk;

  assign rise     = dmem_data_ready & ~ready_q;
  assign last_blk = (count_q + CNT_W'(1)) == nblk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      wcnt_q  <= '0;
      rd_en_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      nblk_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= dmem_data_ready;
      wcnt_q  <= wcnt_d;
      rd_en_q <= rd_en_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
      nblk_q  <= nblk_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    rd_en_d = 1'b0;
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    nblk_d  = nblk_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE, ERR: begin
        if (start) begin
          err_d = 1'b0;
          if (num_blocks == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            nblk_d  = num_blocks;
            count_d = '0;
            rd_en_d = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        rd_en_d = 1'b1;
        wcnt_d  = wcnt_q + WC_W'(1);
        if (rise) begin
          data_d  = dmem_read_data;
          valid_d = 1'b1;
          rd_en_d = 1'b0;
          wcnt_d  = '0;
          state_d = HOLD;
        end else if (wcnt_q == WC_LAST) begin
          rd_en_d = 1'b0;
          wcnt_d  = '0;
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      HOLD: begin
        if (valid_q && blk_ready) begin
          // data is zeroed once consumed so ERR/IDLE present no stale block
          valid_d = 1'b0;
          data_d  = '0;
          count_d = count_q + CNT_W'(1);
          if (last_blk) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rd_en_d = 1'b1;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem_read_enable = rd_en_q;
  assign blk_data         = data_q;
  assign blk_valid        = valid_q;
  assign blk_count        = count_q;
  assign busy             = (state_q == REQ) | (state_q == HOLD);
  assign done             = done_q;
  assign timeout_err      = err_q;

endmodule

// File: tb/tb_dmem_block_fetch.sv
// Bench for dmem_block_fetch: vector table, corner sequences,
// and randomized runs against a scoreboard of DMEM reads.
module tb_dmem_block_fetch;

  localparam int DW = 128;
  localparam int CW = 8;
  localparam int TO = 64;

  localparam logic [DW-1:0] D1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DW-1:0] D2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [DW-1:0] D3 = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_blocks = '0;
  logic          dmem_read_enable;
  logic [DW-1:0] dmem_read_data = '0;
  logic          dmem_data_ready = 1'b0;
  logic [DW-1:0] blk_data;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic [CW-1:0] blk_count;
  logic          busy;
  logic          done;
  logic          timeout_err;

  int errors = 0;
  int checks = 0;

  dmem_block_fetch #(
    .DATA_W (DW),
    .CNT_W  (CW),
    .TIMEOUT(TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .num_blocks      (num_blocks),
    .dmem_read_enable(dmem_read_enable),
    .dmem_read_data  (dmem_read_data),
    .dmem_data_ready (dmem_data_ready),
    .blk_data        (blk_data),
    .blk_valid       (blk_valid),
    .blk_ready       (blk_ready),
    .blk_count       (blk_count),
    .busy            (busy),
    .done            (done),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic          st;
    logic [CW-1:0] nb;
    logic          dr;
    logic [DW-1:0] rd;
    logic          br;
    logic          e_re;
    logic          e_v;
    logic [DW-1:0] e_d;
    logic [CW-1:0] e_cnt;
    logic          e_busy;
    logic          e_done;
    logic          e_err;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(
    input logic st, input logic [CW-1:0] nb, input logic dr,
    input logic [DW-1:0] rd, input logic br,
    input logic re, input logic v, input logic [DW-1:0] d,
    input logic [CW-1:0] cnt, input logic bsy, input logic dn,
    input logic er);
    vec_t r;
    r.st = st; r.nb = nb; r.dr = dr; r.rd = rd; r.br = br;
    r.e_re = re; r.e_v = v; r.e_d = d; r.e_cnt = cnt;
    r.e_busy = bsy; r.e_done = dn; r.e_err = er;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, ".re"}, DW'(dmem_read_enable), '0);
    chk({nm, ".v"}, DW'(blk_valid), '0);
    chk({nm, ".busy"}, DW'(busy), '0);
  endtask

  logic [DW-1:0] expq[$];
  int            n_run;
  int            hs;
  int            lat;
  int            hi;
  int            cyc;
  logic          got_done;
  logic          prev_v;
  logic          prev_acc;
  logic [DW-1:0] prev_d;

  initial begin
    tbl[0]  = mk(1, 1, 0, '0, 1,  1, 0, '0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 1, 0, '0, 1,  1, 0, '0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 0, '0, 1,  1, 0, '0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 1, 1, D1, 1,  0, 1, D1, 0, 1, 0, 0);
    tbl[4]  = mk(0, 1, 1, D1, 1,  0, 0, '0, 1, 0, 1, 0);
    tbl[5]  = mk(0, 1, 0, '0, 1,  0, 0, '0, 1, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, '0, 1,  0, 0, '0, 1, 0, 1, 0);
    tbl[7]  = mk(0, 0, 0, '0, 1,  0, 0, '0, 1, 0, 0, 0);
    tbl[8]  = mk(1, 2, 0, '0, 0,  1, 0, '0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 2, 1, D2, 0,  0, 1, D2, 0, 1, 0, 0);
    tbl[10] = mk(1, 5, 0, '0, 0,  0, 1, D2, 0, 1, 0, 0);
    tbl[11] = mk(0, 5, 0, '0, 0,  0, 1, D2, 0, 1, 0, 0);
    tbl[12] = mk(0, 5, 0, '0, 1,  1, 0, '0, 1, 1, 0, 0);
    tbl[13] = mk(0, 5, 1, D3, 0,  0, 1, D3, 1, 1, 0, 0);
    tbl[14] = mk(0, 5, 0, '0, 1,  0, 0, '0, 2, 0, 1, 0);
    tbl[15] = mk(0, 5, 0, '0, 0,  0, 0, '0, 2, 0, 0, 0);

    // reset state
    #1;
    chk("rst.re", DW'(dmem_read_enable), '0);
    chk("rst.v", DW'(blk_valid), '0);
    chk("rst.data", blk_data, '0);
    chk("rst.cnt", DW'(blk_count), '0);
    chk("rst.busy", DW'(busy), '0);
    chk("rst.done", DW'(done), '0);
    chk("rst.err", DW'(timeout_err), '0);
    @(negedge clk);
    tick;
    rst_n = 1'b1;
    tick;

    // vector table
    for (int i = 0; i < 16; i++) begin
      start           = tbl[i].st;
      num_blocks      = tbl[i].nb;
      dmem_data_ready = tbl[i].dr;
      dmem_read_data  = tbl[i].rd;
      blk_ready       = tbl[i].br;
      tick;
      chk($sformatf("v%0d.re", i), DW'(dmem_read_enable), DW'(tbl[i].e_re));
      chk($sformatf("v%0d.v", i), DW'(blk_valid), DW'(tbl[i].e_v));
      chk($sformatf("v%0d.data", i), blk_data, tbl[i].e_d);
      chk($sformatf("v%0d.cnt", i), DW'(blk_count), DW'(tbl[i].e_cnt));
      chk($sformatf("v%0d.busy", i), DW'(busy), DW'(tbl[i].e_busy));
      chk($sformatf("v%0d.done", i), DW'(done), DW'(tbl[i].e_done));
      chk($sformatf("v%0d.err", i), DW'(timeout_err), DW'(tbl[i].e_err));
    end
    start = 1'b0;
    dmem_data_ready = 1'b0;
    dmem_read_data = '0;
    blk_ready = 1'b0;
    tick;

    // backpressure
    start = 1'b1; num_blocks = 2; tick; start = 1'b0;
    tick;
    dmem_data_ready = 1'b1; dmem_read_data = D1; tick;
    chk("bp.v0", DW'(blk_valid), 1);
    chk("bp.d0", blk_data, D1);
    dmem_data_ready = 1'b0; dmem_read_data = '0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk($sformatf("bp.hold%0d.d", i), blk_data, D1);
      chk($sformatf("bp.hold%0d.v", i), DW'(blk_valid), 1);
      chk($sformatf("bp.hold%0d.re", i), DW'(dmem_read_enable), 0);
      chk($sformatf("bp.hold%0d.done", i), DW'(done), 0);
    end
    blk_ready = 1'b1; tick;
    chk("bp.cnt1", DW'(blk_count), 1);
    chk("bp.re1", DW'(dmem_read_enable), 1);
    chk("bp.done1", DW'(done), 0);
    blk_ready = 1'b0; tick;
    dmem_data_ready = 1'b1; dmem_read_data = D2; tick;
    chk("bp.d1", blk_data, D2);
    dmem_data_ready = 1'b0; blk_ready = 1'b1; tick;
    chk("bp.cnt2", DW'(blk_count), 2);
    chk("bp.done2", DW'(done), 1);
    blk_ready = 1'b0; tick;
    chk("bp.done_once", DW'(done), 0);

    // data_ready stuck high across the block boundary
    start = 1'b1; num_blocks = 2; blk_ready = 1'b1; tick; start = 1'b0;
    dmem_data_ready = 1'b1; dmem_read_data = D1; tick;
    chk("sh.d0", blk_data, D1);
    tick;
    chk("sh.cnt1", DW'(blk_count), 1);
    dmem_read_data = D3;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("sh.stale%0d.v", i), DW'(blk_valid), 0);
      chk($sformatf("sh.stale%0d.re", i), DW'(dmem_read_enable), 1);
    end
    dmem_data_ready = 1'b0; tick;
    chk("sh.low.v", DW'(blk_valid), 0);
    dmem_data_ready = 1'b1; dmem_read_data = D2; tick;
    chk("sh.d1.v", DW'(blk_valid), 1);
    chk("sh.d1", blk_data, D2);
    dmem_data_ready = 1'b0; tick;
    chk("sh.cnt2", DW'(blk_count), 2);
    chk("sh.done", DW'(done), 1);
    blk_ready = 1'b0; tick;

    // timeout, then recovery
    start = 1'b1; num_blocks = 1; tick; start = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk($sformatf("to.req%0d.re", i), DW'(dmem_read_enable), 1);
      chk($sformatf("to.req%0d.err", i), DW'(timeout_err), 0);
      tick;
    end
    chk("to.err", DW'(timeout_err), 1);
    chk("to.done", DW'(done), 0);
    chk_idle_outs("to");
    tick;
    chk("to.sticky", DW'(timeout_err), 1);
    start = 1'b1; num_blocks = 1; blk_ready = 1'b1; tick; start = 1'b0;
    chk("to.clr", DW'(timeout_err), 0);
    chk("to.re2", DW'(dmem_read_enable), 1);
    tick;
    dmem_data_ready = 1'b1; dmem_read_data = D3; tick;
    chk("to.d", blk_data, D3);
    dmem_data_ready = 1'b0; tick;
    chk("to.rdone", DW'(done), 1);
    chk("to.rcnt", DW'(blk_count), 1);
    blk_ready = 1'b0; tick;

    // reset mid-REQ
    start = 1'b1; num_blocks = 3; blk_ready = 1'b1; tick; start = 1'b0;
    dmem_data_ready = 1'b1; dmem_read_data = D1; tick;
    dmem_data_ready = 1'b0; tick;
    chk("mr.pre.re", DW'(dmem_read_enable), 1);
    chk("mr.pre.cnt", DW'(blk_count), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outs("mr");
    chk("mr.cnt", DW'(blk_count), 0);
    chk("mr.data", blk_data, '0);
    chk("mr.done", DW'(done), 0);
    chk("mr.err", DW'(timeout_err), 0);
    blk_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_idle_outs($sformatf("mr.post%0d", i));
    end

    // randomized runs against a read scoreboard
    for (int r = 0; r < 8; r++) begin
      n_run = $urandom_range(1, 8);
      start = 1'b1; num_blocks = CW'(n_run); tick; start = 1'b0;
      hs = 0; got_done = 1'b0; lat = $urandom_range(1, 5); hi = 0;
      prev_v = 1'b0; prev_acc = 1'b0; prev_d = '0; cyc = 0;
      while (!got_done && cyc < 1500) begin
        if (blk_valid) begin
          chk("rnd.qnonempty", DW'(expq.size() > 0), 1);
          if (expq.size() > 0) chk("rnd.data", blk_data, expq[0]);
          if (prev_v && !prev_acc) chk("rnd.stable", blk_data, prev_d);
        end
        chk("rnd.cnt", DW'(blk_count), DW'(hs));
        chk("rnd.excl", DW'(dmem_read_enable & blk_valid), 0);
        chk("rnd.err", DW'(timeout_err), 0);
        if (done) begin
          got_done = 1'b1;
          chk("rnd.nblk", DW'(hs), DW'(n_run));
        end
        if (dmem_data_ready) begin
          if (hi > 0) hi--;
          else dmem_data_ready = 1'b0;
        end else if (dmem_read_enable) begin
          if (lat > 1) lat--;
          else begin
            dmem_data_ready = 1'b1;
            dmem_read_data = {$urandom, $urandom, $urandom, $urandom};
            expq.push_back(dmem_read_data);
            hi = $urandom_range(0, 3);
            lat = $urandom_range(1, 5);
          end
        end
        prev_v = blk_valid;
        prev_d = blk_data;
        blk_ready = 1'($urandom_range(0, 1));
        prev_acc = blk_valid & blk_ready;
        if (prev_acc) begin
          void'(expq.pop_front());
          hs++;
        end
        if (!got_done) begin
          tick;
          cyc++;
        end
      end
      chk($sformatf("rnd%0d.finished", r), DW'(got_done), 1);
      chk($sformatf("rnd%0d.qempty", r), DW'(expq.size()), 0);
      expq.delete();
      dmem_data_ready = 1'b0;
      blk_ready = 1'b0;
      tick;
      chk($sformatf("rnd%0d.done_once", r), DW'(done), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_block_fetch.md
Name: dmem_block_fetch

Overview:
- Fetch controller directly downstream of DMEM: requests 128-bit blocks (plaintext/key material) with read_enable and captures each on the rising edge of data_ready.
- Presents each captured block to the cipher core over a valid/ready handshake.
- Sequences a programmable number of blocks per start command and flags a DMEM timeout.

Parameters:
- DATA_W, 128, block width; matches DMEM read_data.
- CNT_W, 8, width of block count and num_blocks.
- TIMEOUT, 64, max cycles in REQ waiting for a data_ready rising edge before error; must be ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle command; sampled only in IDLE or ERR.
- num_blocks  in  CNT_W  blocks to fetch; sampled with start.
- dmem_read_enable  out  1  read request to DMEM.
- dmem_read_data  in  DATA_W  DMEM read data.
- dmem_data_ready  in  1  DMEM data-ready (level; may stay high).
- blk_data  out  DATA_W  captured block to the core.
- blk_valid  out  1  blk_data is valid.
- blk_ready  in  1  core accepts the block.
- blk_count  out  CNT_W  blocks delivered (handshaken) in the current run.
- busy  out  1  high in REQ or HOLD.
- done  out  1  one-cycle pulse when the run completes.
- timeout_err  out  1  sticky error flag.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including blk_data; internal ready_q and wait counter 0.
- ready_q registers dmem_data_ready every cycle. rise = dmem_data_ready & ~ready_q.
- IDLE:
  - On start with num_blocks==0: done=1 next cycle, stay IDLE, no read issued.
  - On start with num_blocks>0: latch num_blocks, clear blk_count and timeout_err, go to REQ.
- REQ:
  - dmem_read_enable=1 (registered, asserted the cycle after entry). Wait counter increments each cycle.
  - On rise: blk_data<=dmem_read_data, blk_valid<=1, dmem_read_enable<=0, counter cleared, go to HOLD.
  - A level-high data_ready without rise never captures; stale ready from the previous block is ignored.
  - If the counter reaches TIMEOUT-1 without rise: go to ERR, dmem_read_enable<=0, timeout_err<=1.
  - rise wins over timeout in the same cycle.
- HOLD:
  - blk_data and blk_valid are held stable until blk_valid&blk_ready; the block is never dropped or changed.
  - On handshake: blk_valid<=0, blk_count<=blk_count+1.
    - If blk_count+1==latched num_blocks: done pulse, go to IDLE.
    - Otherwise go to REQ.
  - Re-entering REQ re-arms on the next rising edge only.
- ERR: all outputs except timeout_err and blk_count are 0. start restarts the run exactly as from IDLE, clearing timeout_err.
- start while busy is ignored and has no side effects. num_blocks is ignored except with an accepted start.
- busy = (state==REQ)|(state==HOLD).
- blk_count does not wrap within a run (max 2^CNT_W-1 blocks). It holds its final value in IDLE/ERR until the next accepted start.
- rst_n assertion mid-run aborts immediately. No done pulse is generated and the error flag is not set.

Decomposition:
- Shared crypto package: fetch_state_t enum (IDLE, REQ, HOLD, ERR) and BLOCK_W=128, reused by the cipher core and the write-back stage.
- No sub-module needed. The wait counter and edge detector stay inline.
- The valid/ready holding register may later be factored as a generic skid stage, but not for this block.

Test Plan:
- Basic: start, num_blocks=1; DMEM model raises data_ready 3 cycles after read_enable with 128'h00112233445566778899aabbccddeeff; blk_ready=1 -> blk_valid for 1 cycle with that data, blk_count=1, done pulse, read_enable low after capture.
- Backpressure: num_blocks=2, blk_ready held low 10 cycles -> blk_data/blk_valid stable throughout, no second read_enable until handshake, blk_count 1 then 2, single done.
- Stuck-high ready: data_ready held high across the block boundary -> second block is not captured until data_ready falls and rises again; the second block's data is delivered.
- Timeout: DMEM never asserts data_ready, TIMEOUT=64 -> timeout_err=1 after 64 REQ cycles, read_enable 0, busy 0, no done. A new start clears the error and fetches normally.
- Edge cases: num_blocks=0 -> done next cycle, read_enable never asserted. start pulsed during HOLD -> ignored, count unchanged.
- Reset mid-REQ: assert rst_n low with read_enable high -> all outputs 0 immediately (asynchronous). After release the block stays IDLE until start.
